// File: rtl/stepper_move_ctrl.sv
// stepper_move_ctrl
//   Motion sequencer for the stepper phase driver. It accepts a move command
//   (step count, direction, full/half step) over a valid/ready handshake. It
//   then issues one-cycle step pulses on a linear trapezoidal speed profile:
//   accelerate, cruise, decelerate.
//
//   Ports:
//     clk, rst       clock, synchronous active-high reset
//     cmd_valid/rdy  command handshake; cmd_ready is high only in IDLE
//     cmd_steps      number of steps to issue (0 completes immediately)
//     cmd_dir        1 = forward, 0 = reverse (latched into step_dir)
//     cmd_half       half-step request (latched into step_half)
//     abort          controlled stop: ramp down within the steps already used to accelerate
//     step_pulse     one-cycle step strobe
//     busy           high while a move is in progress, including the DONE cycle
//     done           one-cycle pulse when the move ends
//     steps_left     remaining steps
//     coil_off       coil release request
//
//   Build option: STEPPER_HOLD_RELEASE_EN. When it is defined, coil_off
//   releases the coils HOLD_CYCLES cycles after a move ends. When it is
//   undefined, coil_off is tied to 0.
module stepper_move_ctrl #(
  parameter int STEP_W      = 16,
  parameter int DIV_W       = 20,
  parameter int START_DIV   = 65536,
  parameter int MIN_DIV     = 4096,
  parameter int RAMP_DEC    = 256,
  parameter int HOLD_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_dir,
  input  logic              cmd_half,
  input  logic              abort,
  output logic              step_pulse,
  output logic              step_dir,
  output logic              step_half,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] steps_left,
  output logic              coil_off
);

  localparam int                EXT_W       = DIV_W + 1;
  localparam logic [DIV_W-1:0]  START_DIV_C = DIV_W'(START_DIV);
  localparam logic [DIV_W-1:0]  MIN_DIV_C   = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0]  RAMP_C      = DIV_W'(RAMP_DEC);
  localparam logic [DIV_W-1:0]  ONE_D       = DIV_W'(1);
  localparam logic [EXT_W-1:0]  START_EXT   = EXT_W'(START_DIV);
  localparam logic [EXT_W-1:0]  RAMP_EXT    = EXT_W'(RAMP_DEC);
  localparam logic [EXT_W-1:0]  FAST_LIMIT  = EXT_W'(MIN_DIV + RAMP_DEC);
  localparam logic [STEP_W-1:0] ONE_S       = STEP_W'(1);

  if (MIN_DIV < 2 || MIN_DIV > START_DIV || HOLD_CYCLES < 0) begin : g_cfg_check
    $error("stepper_move_ctrl: invalid divider or hold configuration");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEL,
    S_CRUISE,
    S_DECEL,
    S_DONE
  } state_t;

  // Slow down by one ramp step, saturating at the standstill period.
  // The sum is computed one bit wider so it cannot wrap.
  function automatic logic [DIV_W-1:0] div_slower(input logic [DIV_W-1:0] d);
    logic [EXT_W-1:0] sum;
    sum = {1'b0, d} + RAMP_EXT;
    if (sum >= START_EXT) return START_DIV_C;
    return sum[DIV_W-1:0];
  endfunction

  // Speed up by one ramp step, saturating at the cruise period.
  // The comparison is made before subtracting so the result never underflows.
  function automatic logic [DIV_W-1:0] div_faster(input logic [DIV_W-1:0] d);
    if ({1'b0, d} <= FAST_LIMIT) return MIN_DIV_C;
    return d - RAMP_C;
  endfunction

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  cur_div_q, cur_div_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [STEP_W-1:0] accel_q, accel_d;
  logic [STEP_W-1:0] left_q, left_d;
  logic              dir_q, dir_d;
  logic              half_q, half_d;
  logic              pulse_q, pulse_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic [STEP_W-1:0] new_left;
  logic              accept;

  assign accept = ready_q & cmd_valid;

  always_comb begin
    state_d   = state_q;
    cur_div_d = cur_div_q;
    div_cnt_d = div_cnt_q;
    accel_d   = accel_q;
    left_d    = left_q;
    dir_d     = dir_q;
    half_d    = half_q;
    pulse_d   = 1'b0;
    new_left  = left_q - ONE_S;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          dir_d     = cmd_dir;
          half_d    = cmd_half;
          left_d    = cmd_steps;
          cur_div_d = START_DIV_C;
          accel_d   = '0;
          div_cnt_d = START_DIV_C - ONE_D;
          state_d   = (cmd_steps == '0) ? S_DONE : S_ACCEL;
        end
      end
      S_ACCEL, S_CRUISE, S_DECEL: begin
        if (div_cnt_q == '0) begin
          pulse_d = 1'b1;
          left_d  = new_left;
          if (new_left == '0) begin
            state_d = S_DONE;
          end else begin
            case (state_q)
              S_ACCEL: begin
                // Start braking once the remaining steps equal the
                // steps already spent accelerating.
                if (new_left <= accel_q) begin
                  state_d   = S_DECEL;
                  cur_div_d = div_slower(cur_div_q);
                end else begin
                  accel_d   = accel_q + ONE_S;
                  cur_div_d = div_faster(cur_div_q);
                  if (cur_div_d == MIN_DIV_C) state_d = S_CRUISE;
                end
              end
              S_CRUISE: begin
                if (new_left <= accel_q) begin
                  state_d   = S_DECEL;
                  cur_div_d = div_slower(cur_div_q);
                end
              end
              default: cur_div_d = div_slower(cur_div_q);
            endcase
          end
          div_cnt_d = cur_div_d - ONE_D;
        end else begin
          div_cnt_d = div_cnt_q - ONE_D;
        end

        // The abort clamp is applied after any step update in the same cycle.
        // The clamp target is the post-update acceleration count.
        if (abort && (state_q == S_ACCEL || state_q == S_CRUISE) && state_d != S_DONE) begin
          if (left_d > accel_d) left_d = accel_d;
          state_d = (left_d == '0) ? S_DONE : S_DECEL;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    done_d  = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cur_div_q <= START_DIV_C;
      div_cnt_q <= '0;
      accel_q   <= '0;
      left_q    <= '0;
      dir_q     <= 1'b0;
      half_q    <= 1'b0;
      pulse_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cur_div_q <= cur_div_d;
      div_cnt_q <= div_cnt_d;
      accel_q   <= accel_d;
      left_q    <= left_d;
      dir_q     <= dir_d;
      half_q    <= half_d;
      pulse_q   <= pulse_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  assign cmd_ready  = ready_q;
  assign step_pulse = pulse_q;
  assign step_dir   = dir_q;
  assign step_half  = half_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign steps_left = left_q;

`ifdef STEPPER_HOLD_RELEASE_EN
  localparam int HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              coil_off_q, coil_off_d;

  // The hold timer is armed on every entry to DONE, including zero-step and
  // aborted moves. It runs while idle, and a new accept cancels it.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    coil_off_d = coil_off_q;
    if (state_d == S_DONE && state_q != S_DONE) begin
      hold_cnt_d = HOLD_W'(HOLD_CYCLES);
      coil_off_d = 1'b0;
    end else if (accept) begin
      hold_cnt_d = '0;
      coil_off_d = 1'b0;
    end else if (!coil_off_q && (state_q == S_IDLE || state_q == S_DONE)) begin
      if (hold_cnt_q <= HOLD_W'(1)) begin
        hold_cnt_d = '0;
        coil_off_d = 1'b1;
      end else begin
        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= '0;
      coil_off_q <= 1'b1;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      coil_off_q <= coil_off_d;
    end
  end

  assign coil_off = coil_off_q;
`else
  assign coil_off = 1'b0;
`endif

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Testbench for stepper_move_ctrl. A step-level reference model derives the
// expected pulse times, the steps_left values, the done cycle and the abort
// effect for each move. Every output is then compared cycle by cycle.
module tb_stepper_move_ctrl;

  localparam int STEP_W      = 16;
  localparam int DIV_W       = 8;
  localparam int START_DIV   = 8;
  localparam int MIN_DIV     = 4;
  localparam int RAMP_DEC    = 2;
  localparam int HOLD_CYCLES = 5;
`ifdef STEPPER_HOLD_RELEASE_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [STEP_W-1:0] cmd_steps;
  logic              cmd_dir;
  logic              cmd_half;
  logic              abort;
  logic              step_pulse;
  logic              step_dir;
  logic              step_half;
  logic              busy;
  logic              done;
  logic [STEP_W-1:0] steps_left;
  logic              coil_off;

  int n_checks = 0;
  int n_errors = 0;

  int exp_t[$];
  int exp_left[$];
  int exp_done;
  int exp_abort_t;
  int exp_abort_left;

  always #5 clk = ~clk;

  stepper_move_ctrl #(
    .STEP_W(STEP_W), .DIV_W(DIV_W), .START_DIV(START_DIV), .MIN_DIV(MIN_DIV),
    .RAMP_DEC(RAMP_DEC), .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_half(cmd_half), .abort(abort),
    .step_pulse(step_pulse), .step_dir(step_dir), .step_half(step_half),
    .busy(busy), .done(done), .steps_left(steps_left), .coil_off(coil_off)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int slower(input int d);
    return (d + RAMP_DEC >= START_DIV) ? START_DIV : d + RAMP_DEC;
  endfunction

  function automatic int faster(input int d);
    return (d - RAMP_DEC <= MIN_DIV) ? MIN_DIV : d - RAMP_DEC;
  endfunction

  // Step-level profile. Cycle 0 is the accept edge and the first step lands at
  // START_DIV. Each step is followed by the period chosen at that step.
  // ph: 0 = speeding up, 1 = cruising, 2 = slowing down.
  // abort_k > 0 aborts one cycle after pulse abort_k. abort_k == 0 aborts at cycle 2.
  task automatic build_model(input int n, input int abort_k);
    int left, div, acc, ph, t, k;
    exp_t.delete();
    exp_left.delete();
    exp_abort_t    = -1;
    exp_abort_left = 0;
    exp_done       = -1;
    left = n; div = START_DIV; acc = 0; ph = 0; t = START_DIV; k = 0;
    if (n == 0) begin
      exp_done = 0;
    end else if (abort_k == 0) begin
      exp_done = 2; exp_abort_t = 2; exp_abort_left = 0;
    end else begin
      while (exp_done < 0) begin
        exp_t.push_back(t);
        left--; k++;
        if (left == 0) begin
          exp_left.push_back(0);
          exp_done = t;
        end else begin
          if (ph == 0) begin
            if (left <= acc) begin ph = 2; div = slower(div); end
            else begin acc++; div = faster(div); if (div == MIN_DIV) ph = 1; end
          end else if (ph == 1) begin
            if (left <= acc) begin ph = 2; div = slower(div); end
          end else begin
            div = slower(div);
          end
          exp_left.push_back(left);
          if (k == abort_k && ph != 2) begin
            if (acc < left) left = acc;
            ph = 2;
            exp_abort_t    = t + 1;
            exp_abort_left = left;
            if (left == 0) exp_done = t + 1;
          end
          t += div;
        end
      end
    end
  endtask

  // Issue one command from IDLE and check every output each cycle until the
  // hold window after done has passed.
  task automatic run_move(input int n, input bit dir, input bit half, input int abort_k, input bit noise);
    int  drive_abort_t, p;
    bit  exp_pulse, exp_coil;
    build_model(n, abort_k);
    drive_abort_t = -1;
    if (n > 0 && abort_k == 0) drive_abort_t = 2;
    else if (n > 0 && abort_k > 0) drive_abort_t = exp_t[abort_k-1] + 1;
    cmd_steps = STEP_W'(n); cmd_dir = dir; cmd_half = half; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_steps = STEP_W'($urandom); cmd_dir = ~dir; cmd_half = ~half;
    p = 0;
    for (int c = 0; c <= exp_done + 6; c++) begin
      @(negedge clk);
      exp_pulse = (p < exp_t.size()) && (exp_t[p] == c);
      check_val($sformatf("pulse n%0d c%0d", n, c), step_pulse, exp_pulse);
      if (exp_pulse) begin
        check_val($sformatf("left n%0d c%0d", n, c), steps_left, exp_left[p]);
        p++;
      end
      if (c == exp_abort_t)
        check_val($sformatf("abort_left n%0d c%0d", n, c), steps_left, exp_abort_left);
      check_val($sformatf("done n%0d c%0d", n, c), done, (c == exp_done));
      check_val($sformatf("busy n%0d c%0d", n, c), busy, (c <= exp_done));
      check_val($sformatf("ready n%0d c%0d", n, c), cmd_ready, (c > exp_done));
      if (c <= exp_done) begin
        check_val($sformatf("dir n%0d c%0d", n, c), step_dir, dir);
        check_val($sformatf("half n%0d c%0d", n, c), step_half, half);
      end
      if (c == exp_done) check_val($sformatf("left_end n%0d", n), steps_left, 0);
      exp_coil = HOLD_EN && (c >= exp_done + HOLD_CYCLES);
      check_val($sformatf("coil n%0d c%0d", n, c), coil_off, exp_coil);
      abort     = (c + 1 == drive_abort_t);
      cmd_valid = noise && (c < exp_done) && ($urandom_range(0, 1) == 1);
      if (cmd_valid) begin
        cmd_steps = STEP_W'($urandom_range(0, 30));
        cmd_dir   = ~dir;
        cmd_half  = ~half;
      end
    end
    cmd_valid = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_ready"}, cmd_ready, 1);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_pulse"}, step_pulse, 0);
    check_val({tag, "_dir"}, step_dir, 0);
    check_val({tag, "_half"}, step_half, 0);
    check_val({tag, "_left"}, steps_left, 0);
    check_val({tag, "_coil"}, coil_off, HOLD_EN);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses, n, k;
    rst = 1'b1; cmd_valid = 1'b0; cmd_steps = '0; cmd_dir = 1'b0; cmd_half = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    run_move(10, 1'b1, 1'b0, -1, 1'b0);
    run_move(3, 1'b0, 1'b1, -1, 1'b0);
    run_move(0, 1'b1, 1'b1, -1, 1'b0);
    run_move(10, 1'b1, 1'b0, 4, 1'b0);
    run_move(5, 1'b0, 1'b0, 0, 1'b0);
    run_move(12, 1'b1, 1'b1, 11, 1'b1);

    // Reset in the middle of a move
    cmd_steps = 16'd10; cmd_dir = 1'b1; cmd_half = 1'b1; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("midrst");
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (step_pulse) pulses++;
    end
    check_val("midrst_no_pulses", pulses, 0);
    check_val("midrst_idle", busy, 0);
    run_move(1, 1'b0, 1'b1, -1, 1'b0);

    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(0, 20);
      k = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n) : -1;
      run_move(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), k, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
